// File: rtl/fetch_queue_stage.sv
// Instruction fetch front end: issues PC-ordered requests to a variable-latency
// instruction memory, queues returned words with their PCs and feeds the IF/ID register.
module fetch_queue_stage #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam int          QAW = $clog2(DEPTH);
  localparam int          QCW = $clog2(DEPTH + 1);
  localparam int          PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int          OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Fetch PC and request bookkeeping
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PAW-1:0]  pend_wr_q, pend_wr_d;
  logic [PAW-1:0]  pend_rd_q, pend_rd_d;
  logic [OCW-1:0]  out_cnt_q, out_cnt_d;
  logic [OCW-1:0]  drop_q, drop_d;
  logic [XLEN-1:0] pend_pc_q [MAX_OUTSTANDING];

  // Instruction queue
  logic [XLEN-1:0] q_pc_mem    [DEPTH];
  logic [31:0]     q_instr_mem [DEPTH];
  logic [QAW-1:0]  q_head_q, q_head_d;
  logic [QAW-1:0]  q_tail_q, q_tail_d;
  logic [QCW-1:0]  q_count_q, q_count_d;

  // IF/ID register
  logic [31:0]     instr_dec_q, instr_dec_d;
  logic [XLEN-1:0] pc_dec_q, pc_dec_d;
  logic [XLEN-1:0] pc4_dec_q, pc4_dec_d;
  logic            valid_dec_q, valid_dec_d;

  logic credit_ok;
  logic req_fire;
  logic resp_fire;
  logic q_push;
  logic q_pop;
  int   occupancy;

  function automatic logic [PAW-1:0] pend_next(input logic [PAW-1:0] p);
    if (int'(p) == MAX_OUTSTANDING - 1) return '0;
    return p + 1'b1;
  endfunction

  // Credits cover both queued words and words still in flight, so a
  // response always finds a free queue slot.
  always_comb begin
    occupancy      = int'(q_count_q) + int'(out_cnt_q);
    credit_ok      = (occupancy < DEPTH) && (int'(out_cnt_q) < MAX_OUTSTANDING);
    imem_req_valid = ~reset & ~PCSrcE & credit_ok;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid & imem_req_ready;
    resp_fire      = imem_resp_valid & (out_cnt_q != '0);
    q_push         = resp_fire & (drop_q == '0) & ~PCSrcE;
    q_pop          = ~FlushD & ~StallD & (q_count_q != '0);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (PCSrcE) fetch_pc_d = PCTargetE;
    else if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);

    pend_wr_d = req_fire ? pend_next(pend_wr_q) : pend_wr_q;
    pend_rd_d = resp_fire ? pend_next(pend_rd_q) : pend_rd_q;

    out_cnt_d = out_cnt_q;
    if (req_fire && !resp_fire) out_cnt_d = out_cnt_q + 1'b1;
    else if (!req_fire && resp_fire) out_cnt_d = out_cnt_q - 1'b1;

    // Everything still in flight at a redirect belongs to the wrong path.
    drop_d = drop_q;
    if (PCSrcE) drop_d = out_cnt_q - OCW'(resp_fire);
    else if (resp_fire && drop_q != '0) drop_d = drop_q - 1'b1;
  end

  always_comb begin
    q_head_d  = q_head_q;
    q_tail_d  = q_tail_q;
    q_count_d = q_count_q;
    if (PCSrcE) begin
      q_head_d  = '0;
      q_tail_d  = '0;
      q_count_d = '0;
    end else begin
      if (q_pop)  q_head_d = q_head_q + 1'b1;
      if (q_push) q_tail_d = q_tail_q + 1'b1;
      if (q_push && !q_pop) q_count_d = q_count_q + 1'b1;
      else if (!q_push && q_pop) q_count_d = q_count_q - 1'b1;
    end
  end

  always_comb begin
    instr_dec_d = instr_dec_q;
    pc_dec_d    = pc_dec_q;
    pc4_dec_d   = pc4_dec_q;
    valid_dec_d = valid_dec_q;
    if (FlushD) begin
      instr_dec_d = NOP;
      pc_dec_d    = '0;
      pc4_dec_d   = '0;
      valid_dec_d = 1'b0;
    end else if (!StallD) begin
      if (q_count_q != '0) begin
        instr_dec_d = q_instr_mem[q_head_q];
        pc_dec_d    = q_pc_mem[q_head_q];
        pc4_dec_d   = q_pc_mem[q_head_q] + XLEN'(4);
        valid_dec_d = 1'b1;
      end else begin
        instr_dec_d = NOP;
        valid_dec_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      pend_wr_q   <= '0;
      pend_rd_q   <= '0;
      out_cnt_q   <= '0;
      drop_q      <= '0;
      q_head_q    <= '0;
      q_tail_q    <= '0;
      q_count_q   <= '0;
      instr_dec_q <= NOP;
      pc_dec_q    <= '0;
      pc4_dec_q   <= '0;
      valid_dec_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_wr_q   <= pend_wr_d;
      pend_rd_q   <= pend_rd_d;
      out_cnt_q   <= out_cnt_d;
      drop_q      <= drop_d;
      q_head_q    <= q_head_d;
      q_tail_q    <= q_tail_d;
      q_count_q   <= q_count_d;
      instr_dec_q <= instr_dec_d;
      pc_dec_q    <= pc_dec_d;
      pc4_dec_q   <= pc4_dec_d;
      valid_dec_q <= valid_dec_d;
    end
  end

  // Storage arrays carry no reset; their contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (req_fire) pend_pc_q[pend_wr_q] <= imem_req_addr;
    if (q_push) begin
      q_pc_mem[q_tail_q]    <= pend_pc_q[pend_rd_q];
      q_instr_mem[q_tail_q] <= imem_resp_data;
    end
  end

  assign InstrD   = instr_dec_q;
  assign PCD      = pc_dec_q;
  assign PCPlus4D = pc4_dec_q;
  assign ValidD   = valid_dec_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: a startup/stall vector table plus
// hand-written redirect, back-pressure, wrap and mid-operation reset sequences.
module tb_fetch_queue_stage;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, PCSrcE, StallD, FlushD;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_queue_stage #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .FlushD(FlushD),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        stall;
    logic        exp_valid;
    logic [31:0] exp_pcd;
    logic [31:0] exp_instr;
    logic        exp_rv;
    logic [31:0] exp_addr;
  } vec_t;

  mreq_t       mq[$];
  vec_t        tbl[11];
  int          cyc = 0, lat = 1, vec_cnt = 0, miss_cnt = 0, ovf = 0, fires = 0;
  logic [31:0] exp_next, req_expect, prev_instr, prev_pc, prev_pc4;
  logic        prev_valid, loaded;
  logic [31:0] loaded_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: memory model drives the response, request handshake is
  // recorded, then the IF/ID outputs are checked against program order.
  task automatic tick();
    logic        fire, popm;
    logic [31:0] faddr;
    popm = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memf(mq[0].addr);
      popm = 1'b1;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    fire  = imem_req_valid & imem_req_ready;
    faddr = imem_req_addr;
    if (reset) chk("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
    else if (PCSrcE) chk("req_valid_on_redirect", 32'(imem_req_valid), 32'd0);
    if (fire) begin
      chk("req_addr_order", faddr, req_expect);
      req_expect += 32'd4;
      fires++;
    end
    @(posedge clk);
    #1;
    if (popm) void'(mq.pop_front());
    if (fire) mq.push_back('{faddr, cyc + lat});
    cyc++;
    loaded = 1'b0;
    if (reset || FlushD) begin
      chk("clr_valid", 32'(ValidD), 32'd0);
      chk("clr_instr", InstrD, NOP);
      chk("clr_pcd", PCD, 32'd0);
      chk("clr_pc4", PCPlus4D, 32'd0);
    end else if (StallD) begin
      chk("hold_valid", 32'(ValidD), 32'(prev_valid));
      chk("hold_instr", InstrD, prev_instr);
      chk("hold_pcd", PCD, prev_pc);
      chk("hold_pc4", PCPlus4D, prev_pc4);
    end else if (ValidD) begin
      chk("seq_pcd", PCD, exp_next);
      chk("seq_instr", InstrD, memf(exp_next));
      chk("seq_pc4", PCPlus4D, exp_next + 32'd4);
      loaded    = 1'b1;
      loaded_pc = PCD;
      exp_next += 32'd4;
    end else begin
      chk("bubble_instr", InstrD, NOP);
      chk("bubble_pcd_hold", PCD, prev_pc);
    end
    if (reset) begin
      exp_next   = RESET_PC;
      req_expect = RESET_PC;
    end else if (PCSrcE) begin
      exp_next   = PCTargetE;
      req_expect = PCTargetE;
    end
    prev_valid = ValidD;
    prev_instr = InstrD;
    prev_pc    = PCD;
    prev_pc4   = PCPlus4D;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc, input int max);
    logic        seen;
    logic [31:0] got;
    seen = 1'b0;
    got  = 32'hFFFF_FFFF;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (loaded) begin
        seen = 1'b1;
        got  = loaded_pc;
      end
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) chk({name, "_pc"}, got, exp_pc);
  endtask

  task automatic redirect(input logic [31:0] target);
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = target;
    tick();
    PCSrcE = 1'b0; FlushD = 1'b0;
  endtask

  // A push into a full queue without a matching pop would lose a word.
  always @(negedge clk) begin
    if (reset === 1'b0 && dut.q_push && int'(dut.q_count_q) == DEPTH && !dut.q_pop) ovf++;
  end

  initial begin
    logic [31:0] held;
    int          f0;
    reset = 1'b1; PCSrcE = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCTargetE = 32'h0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    exp_next = RESET_PC; req_expect = RESET_PC;
    prev_valid = 1'b0; prev_instr = NOP; prev_pc = 32'h0; prev_pc4 = 32'h0;
    loaded = 1'b0; loaded_pc = 32'h0;

    // Startup with 1-cycle latency, then a two-cycle stall filling the queue.
    tbl[0]  = '{1'b0, 1'b0, 32'd0,  NOP,         1'b1, 32'd4};
    tbl[1]  = '{1'b0, 1'b0, 32'd0,  NOP,         1'b1, 32'd8};
    tbl[2]  = '{1'b0, 1'b1, 32'd0,  memf(32'd0), 1'b1, 32'd12};
    tbl[3]  = '{1'b0, 1'b1, 32'd4,  memf(32'd4), 1'b1, 32'd16};
    tbl[4]  = '{1'b0, 1'b1, 32'd8,  memf(32'd8), 1'b1, 32'd20};
    tbl[5]  = '{1'b0, 1'b1, 32'd12, memf(32'd12), 1'b1, 32'd24};
    tbl[6]  = '{1'b1, 1'b1, 32'd12, memf(32'd12), 1'b1, 32'd28};
    tbl[7]  = '{1'b1, 1'b1, 32'd12, memf(32'd12), 1'b0, 32'd32};
    tbl[8]  = '{1'b0, 1'b1, 32'd16, memf(32'd16), 1'b1, 32'd32};
    tbl[9]  = '{1'b0, 1'b1, 32'd20, memf(32'd20), 1'b1, 32'd36};
    tbl[10] = '{1'b0, 1'b1, 32'd24, memf(32'd24), 1'b1, 32'd40};

    repeat (2) tick();
    chk("reset_req_addr", imem_req_addr, RESET_PC);
    chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 11; k++) begin
      StallD = tbl[k].stall;
      tick();
      chk($sformatf("tbl%0d_valid", k), 32'(ValidD), 32'(tbl[k].exp_valid));
      chk($sformatf("tbl%0d_pcd", k), PCD, tbl[k].exp_pcd);
      chk($sformatf("tbl%0d_instr", k), InstrD, tbl[k].exp_instr);
      chk($sformatf("tbl%0d_req_valid", k), 32'(imem_req_valid), 32'(tbl[k].exp_rv));
      chk($sformatf("tbl%0d_req_addr", k), imem_req_addr, tbl[k].exp_addr);
    end
    StallD = 1'b0;

    // Long stall: bounded by queue credits, D frozen, no gaps after release.
    StallD = 1'b1; fires = 0;
    repeat (10) tick();
    chk("stall_fires_le_depth", 32'(fires <= DEPTH), 32'd1);
    StallD = 1'b0;
    repeat (12) tick();

    // Memory back-pressure: address held, queue drains to NOP bubbles.
    imem_req_ready = 1'b0;
    held = imem_req_addr;
    repeat (5) begin
      tick();
      chk("addr_stable", imem_req_addr, held);
    end
    chk("drain_valid", 32'(ValidD), 32'd0);
    chk("drain_instr", InstrD, NOP);
    chk("drain_req_valid", 32'(imem_req_valid), 32'd1);

    // Redirect with two requests in flight and no same-cycle response.
    lat = 3; imem_req_ready = 1'b1; f0 = fires;
    tick(); tick();
    chk("two_issued", 32'(fires - f0), 32'd2);
    redirect(32'h0000_0100);
    wait_valid("redir", 32'h0000_0100, 20);
    repeat (6) tick();

    // Redirect in the same cycle as the first stale response.
    imem_req_ready = 1'b0;
    repeat (8) tick();
    imem_req_ready = 1'b1;
    tick(); tick(); tick();
    redirect(32'h0000_0200);
    wait_valid("redir_resp", 32'h0000_0200, 20);
    repeat (4) tick();

    // PC increment wraps modulo 2^32.
    imem_req_ready = 1'b0;
    repeat (8) tick();
    imem_req_ready = 1'b1;
    redirect(32'hFFFF_FFF8);
    wait_valid("wrap", 32'hFFFF_FFF8, 20);
    repeat (10) tick();
    chk("wrap_progress", 32'(exp_next < 32'h0000_0100), 32'd1);

    // Mid-operation reset: late responses must be ignored.
    imem_req_ready = 1'b0;
    repeat (8) tick();
    imem_req_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; imem_req_ready = 1'b0;
    repeat (4) begin
      tick();
      chk("late_resp_ignored", 32'(ValidD), 32'd0);
    end
    imem_req_ready = 1'b1;
    wait_valid("after_reset", RESET_PC, 20);
    repeat (3) tick();

    chk("no_full_push", 32'(ovf), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
